// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for a 5-stage RV32I pipeline
//   Inputs : clk, reset (async, active-high), ID source regs/uses, EX rd/load/branch,
//            MEM request/ready handshake.
//   Outputs: per-stage load enables and flushes (combinational from state + inputs),
//            sticky mem_timeout, perf counters stall_cycles / flush_count.
//   Macro  : PIPE_PERF_EN builds the perf counters; otherwise they read 0.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flush_pending;
    logic             w_freeze, w_load_use, w_do_flush, w_err, w_timeout_hit;
    logic [CNT_W-1:0] w_cnt_next;
    assign w_freeze   = mem_req & ~mem_ready;
    assign w_load_use = ex_mem_read & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign w_do_flush = ex_branch_taken | r_flush_pending;
    assign w_err      = (r_state == ERROR);
    // The first freeze cycle seen from RUN already counts as one.
    assign w_cnt_next    = (r_state == RUN) ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + 1'b1);
    assign w_timeout_hit = (MEM_TIMEOUT != 0) && (w_cnt_next >= TIMEOUT);
    // Order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, mem_timeout
    always_comb begin
        {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, mem_timeout} =
            reset      ? 8'b0010_1000 :
            w_err      ? 8'b0000_0001 :
            w_freeze   ? 8'b0000_0000 :
            w_do_flush ? 8'b1111_1110 :
            w_load_use ? 8'b0001_1110 :
                         8'b1101_0110;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= RUN;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
        end else if (!w_err) begin
            if (w_freeze) begin
                r_cnt   <= w_cnt_next;
                r_state <= w_timeout_hit ? ERROR : MEM_WAIT;
                if (ex_branch_taken) r_flush_pending <= 1'b1;
            end else begin
                // Any pending flush is applied this cycle, so it can be dropped.
                r_cnt           <= '0;
                r_state         <= RUN;
                r_flush_pending <= 1'b0;
            end
        end
    end
`ifdef PIPE_PERF_EN
    logic [31:0] r_stall_cycles, r_flush_count;
    logic        w_apply_flush;
    assign w_apply_flush = ~w_err & ~w_freeze & w_do_flush;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_en) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_apply_flush) r_flush_count <= r_flush_count + 32'd1;
        end
    end
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif
endmodule
